// File: rtl/txhex_uart.sv
// txhex_uart: prints a DW-bit word as ASCII hex over an 8N1 serial line.
// Frame: optional "0x", DW/4 hex digits MSB-first, optional "\r\n" / "\n".
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | nothing in flight, line idle high
// S_PREFIX0 | sending '0' of the "0x" prefix
// S_PREFIX1 | sending 'x' of the "0x" prefix
// S_DIGIT   | sending one hex digit taken from the top nibble
// S_EOL_CR  | sending carriage return (0x0d)
// S_EOL_LF  | sending line feed (0x0a)
module txhex_uart #(
  parameter int DW              = 32,
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int PREFIX          = 1,
  parameter int UPPER           = 0,
  parameter int EOL             = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  input  logic [DW-1:0] i_data,
  output logic          o_busy,
  output logic          o_uart_tx
);

  localparam int          NDIG      = DW / 4;
  localparam int          NCHAR     = 2 * PREFIX + NDIG + EOL;
  localparam logic [23:0] BAUD_LAST = 24'(CLOCKS_PER_BAUD - 1);
  localparam logic [4:0]  CHAR_LAST = 5'(NCHAR - 1);
  localparam logic [4:0]  DIG_INIT  = 5'(NDIG);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFIX0, S_PREFIX1, S_DIGIT, S_EOL_CR, S_EOL_LF
  } state_t;

  state_t        state_q, state_d, nxt_state;
  logic [DW-1:0] sreg_q, sreg_d;
  logic [4:0]    dig_left_q, dig_left_d;
  logic [4:0]    char_idx_q, char_idx_d;
  logic [7:0]    char_q, char_d;
  logic [3:0]    bit_q, bit_d;
  logic [23:0]   baud_q, baud_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          load;
  logic [DW-1:0] src;
  logic [4:0]    dig_base;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return ((UPPER != 0) ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
  endfunction

  // Which character follows the one currently in flight (from idle: the first one).
  always_comb begin
    nxt_state = S_IDLE;
    case (state_q)
      S_IDLE:    nxt_state = (PREFIX != 0) ? S_PREFIX0 : S_DIGIT;
      S_PREFIX0: nxt_state = S_PREFIX1;
      S_PREFIX1: nxt_state = S_DIGIT;
      S_DIGIT: begin
        if (dig_left_q != 5'd0) nxt_state = S_DIGIT;
        else if (EOL == 2)      nxt_state = S_EOL_CR;
        else if (EOL == 1)      nxt_state = S_EOL_LF;
        else                    nxt_state = S_IDLE;
      end
      S_EOL_CR:  nxt_state = S_EOL_LF;
      default:   nxt_state = S_IDLE;
    endcase
  end

  // Bit engine and character sequencer: baud countdown, bit stepping, char loading.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    dig_left_d = dig_left_q;
    char_idx_d = char_idx_q;
    char_d     = char_q;
    bit_d      = bit_q;
    baud_d     = baud_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    load       = 1'b0;
    src        = sreg_q;
    dig_base   = dig_left_q;

    if (!busy_q) begin
      if (i_stb) begin
        load       = 1'b1;
        busy_d     = 1'b1;
        char_idx_d = 5'd0;
        src        = i_data;
        dig_base   = DIG_INIT;
      end
    end else if (baud_q != 24'd0) begin
      baud_d = baud_q - 24'd1;
    end else if (bit_q != 4'd9) begin
      bit_d  = bit_q + 4'd1;
      baud_d = BAUD_LAST;
      tx_d   = (bit_q == 4'd8) ? 1'b1 : char_q[bit_q[2:0]];
    end else if (char_idx_q == CHAR_LAST) begin
      busy_d     = 1'b0;
      state_d    = S_IDLE;
      char_idx_d = 5'd0;
      bit_d      = 4'd0;
      tx_d       = 1'b1;
    end else begin
      load       = 1'b1;
      char_idx_d = char_idx_q + 5'd1;
    end

    if (load) begin
      state_d    = nxt_state;
      bit_d      = 4'd0;
      baud_d     = BAUD_LAST;
      tx_d       = 1'b0;
      sreg_d     = src;
      dig_left_d = dig_base;
      case (nxt_state)
        S_PREFIX0: char_d = 8'h30;
        S_PREFIX1: char_d = 8'h78;
        S_DIGIT: begin
          char_d     = hex_char(src[DW-1 -: 4]);
          sreg_d     = src << 4;
          dig_left_d = dig_base - 5'd1;
        end
        S_EOL_CR:  char_d = 8'h0d;
        S_EOL_LF:  char_d = 8'h0a;
        default:   char_d = 8'h00;
      endcase
    end
  end

  // State registers; reset drops the line to idle and abandons any partial frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      dig_left_q <= 5'd0;
      char_idx_q <= 5'd0;
      char_q     <= 8'h00;
      bit_q      <= 4'd0;
      baud_q     <= 24'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      dig_left_q <= dig_left_d;
      char_idx_q <= char_idx_d;
      char_q     <= char_d;
      bit_q      <= bit_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_txhex_uart.sv
// Bench for txhex_uart: two instances (32-bit "0x..\r\n" lower case, 8-bit bare upper case)
// compared cycle by cycle against an ideal serial waveform built from the expected text.
module tb_txhex_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb32, busy32, tx32;
  logic [31:0] data32;
  logic        stb8, busy8, tx8;
  logic [7:0]  data8;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  txhex_uart #(.DW(32), .CLOCKS_PER_BAUD(4), .PREFIX(1), .UPPER(0), .EOL(2)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_stb(stb32), .i_data(data32),
    .o_busy(busy32), .o_uart_tx(tx32)
  );

  txhex_uart #(.DW(8), .CLOCKS_PER_BAUD(2), .PREFIX(0), .UPPER(1), .EOL(0)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_stb(stb8), .i_data(data8),
    .o_busy(busy8), .o_uart_tx(tx8)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx8 : tx32;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy8 : busy32;
  endfunction

  task automatic drive(input int sel, input logic s, input logic [63:0] d);
    if (sel != 0) begin stb8 = s; data8 = d[7:0]; end
    else begin stb32 = s; data32 = d[31:0]; end
  endtask

  task automatic drop_stb(input int sel);
    if (sel != 0) stb8 = 1'b0; else stb32 = 1'b0;
  endtask

  // Expected text of one frame, straight from the formatting rules.
  task automatic build_exp(input logic [63:0] d, input int dw, input int pre, input int up, input int eol);
    exp_q.delete();
    if (pre != 0) begin exp_q.push_back(8'h30); exp_q.push_back(8'h78); end
    for (int i = dw / 4 - 1; i >= 0; i--) begin
      int nib;
      nib = int'((d >> (4 * i)) & 64'hf);
      if (nib < 10) exp_q.push_back(8'(48 + nib));
      else          exp_q.push_back(8'(((up != 0) ? 65 : 97) + nib - 10));
    end
    if (eol == 2) exp_q.push_back(8'h0d);
    if (eol >= 1) exp_q.push_back(8'h0a);
  endtask

  task automatic strobe(input int sel, input logic [63:0] d);
    drive(sel, 1'b1, d);
    @(posedge clk);
  endtask

  // Called right after the accepting edge; follows the whole frame plus one idle cycle.
  task automatic watch(input int sel, input logic [63:0] d, input bit hold, input int mid_at, input string tag);
    int cpb, len, wave_bad, busy_bad;
    logic [7:0] rx;
    cpb = (sel != 0) ? 2 : 4;
    if (sel != 0) build_exp(d, 8, 0, 1, 0);
    else          build_exp(d, 32, 1, 0, 2);
    len = 10 * cpb * exp_q.size();
    wave_bad = 0;
    busy_bad = 0;
    rx = 8'h00;
    for (int k = 0; k < len; k++) begin
      int j, b;
      logic want;
      logic [7:0] c;
      @(negedge clk);
      if (k == 0 && !hold) drop_stb(sel);
      if (mid_at >= 0 && k == mid_at) drive(sel, 1'b1, 64'hffff_ffff_ffff_ffff);
      if (mid_at >= 0 && k == mid_at + 1) drop_stb(sel);
      j = k / (10 * cpb);
      b = (k / cpb) % 10;
      c = exp_q[j];
      want = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : c[b - 1];
      if (tx_of(sel) !== want) wave_bad++;
      if (busy_of(sel) !== 1'b1) busy_bad++;
      if (k % cpb == cpb / 2) begin
        if (b >= 1 && b <= 8) rx[b - 1] = tx_of(sel);
        if (b == 9) check_val($sformatf("%s char%0d", tag, j), 64'(rx), 64'(c));
      end
    end
    check_val({tag, " wave mismatches"}, 64'(wave_bad), 64'd0);
    check_val({tag, " busy low cycles"}, 64'(busy_bad), 64'd0);
    @(negedge clk);
    check_val({tag, " busy after frame"}, 64'(busy_of(sel)), 64'd0);
    check_val({tag, " tx after frame"}, 64'(tx_of(sel)), 64'd1);
  endtask

  initial begin
    logic [31:0] r32;
    rst = 1'b1;
    stb32 = 1'b0; data32 = '0;
    stb8 = 1'b0;  data8 = '0;
    repeat (2) @(negedge clk);
    check_val("reset tx32", 64'(tx32), 64'd1);
    check_val("reset busy32", 64'(busy32), 64'd0);
    check_val("reset tx8", 64'(tx8), 64'd1);
    check_val("reset busy8", 64'(busy8), 64'd0);
    rst = 1'b0;

    strobe(0, 64'h1234abcd);
    watch(0, 64'h1234abcd, 1'b0, -1, "basic32");

    strobe(1, 64'h5a);
    watch(1, 64'h5a, 1'b0, -1, "hex5a");
    strobe(1, 64'h00);
    watch(1, 64'h00, 1'b0, -1, "hex00");

    strobe(0, 64'h1234abcd);
    watch(0, 64'h1234abcd, 1'b0, 100, "busy_stb");
    strobe(0, 64'h00000001);
    watch(0, 64'h00000001, 1'b0, -1, "back2back");

    // Reset during the third digit's start bit.
    strobe(0, 64'h1234abcd);
    for (int k = 0; k <= 161; k++) begin
      @(negedge clk);
      if (k == 0) stb32 = 1'b0;
    end
    check_val("pre-reset tx", 64'(tx32), 64'd0);
    check_val("pre-reset busy", 64'(busy32), 64'd1);
    rst = 1'b1;
    #1;
    check_val("async reset tx", 64'(tx32), 64'd1);
    check_val("async reset busy", 64'(busy32), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    strobe(0, 64'hdeadbeef);
    watch(0, 64'hdeadbeef, 1'b0, -1, "after_reset");

    // Strobe held high: frames repeat with one idle cycle between them.
    stb32 = 1'b1;
    data32 = 32'hc0ffee42;
    @(posedge clk);
    watch(0, 64'hc0ffee42, 1'b1, -1, "hold0");
    watch(0, 64'hc0ffee42, 1'b1, -1, "hold1");
    stb32 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      r32 = $urandom;
      strobe(0, 64'(r32));
      watch(0, 64'(r32), 1'b0, -1, $sformatf("rand32_%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      r32 = 32'($urandom_range(0, 255));
      strobe(1, 64'(r32));
      watch(1, 64'(r32), 1'b0, -1, $sformatf("rand8_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
